// File: rtl/ifu_cpack_pkg.sv
// Shared constants for the RV32 -> RVC compressor/packer: opcode fields, packer states, pad parcel.
package ifu_cpack_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [15:0] C_NOP = 16'h0001;

  // Registers reachable by the 3-bit rd'/rs1'/rs2' fields (x8-x15).
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/ifu_compress_enc.sv
// Combinational RV32 -> RVC encoder; is_c flags a bit-exact 16-bit equivalent in c_parcel.
module ifu_compress_enc
  import ifu_cpack_pkg::*;
(
  input  logic [31:0] in_instr,
  output logic        is_c,
  output logic [15:0] c_parcel
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        imm_6b;
  logic [1:0]  ca_op;

  assign opc   = in_instr[6:0];
  assign rd    = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign f7    = in_instr[31:25];
  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};
  // Immediate fits the signed 6-bit field of c.addi/c.li/c.andi.
  assign imm_6b = (&imm_i[11:5]) | ~(|imm_i[11:5]);

  always_comb begin
    ca_op = 2'b00;
    unique case (f3)
      F3_XOR:  ca_op = 2'b01;
      F3_OR:   ca_op = 2'b10;
      F3_AND:  ca_op = 2'b11;
      default: ca_op = 2'b00;
    endcase
  end

  always_comb begin
    is_c     = 1'b0;
    c_parcel = 16'h0000;
    case (opc)
      OPC_OP_IMM: begin
        case (f3)
          F3_ADD: begin
            if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
              is_c = 1'b1; c_parcel = C_NOP;
            end else if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && imm_6b) begin
              is_c = 1'b1; c_parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (rd != 5'd0 && rs1 == 5'd0 && imm_6b) begin
              is_c = 1'b1; c_parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (rd == 5'd2 && rs1 == 5'd2 && imm_i != 12'd0 && imm_i[3:0] == 4'd0 &&
                         (imm_i[11:9] == 3'b000 || imm_i[11:9] == 3'b111)) begin
              is_c = 1'b1;
              c_parcel = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
            end else if (is_creg(rd) && rs1 == 5'd2 && imm_i != 12'd0 && imm_i[1:0] == 2'd0 &&
                         imm_i[11:10] == 2'd0) begin
              is_c = 1'b1;
              c_parcel = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
            end
          end
          F3_SLL: begin
            if (f7 == F7_ZERO && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
              is_c = 1'b1; c_parcel = {3'b000, 1'b0, rd, rs2, 2'b10};
            end
          end
          F3_SR: begin
            if ((f7 == F7_ZERO || f7 == F7_ALT) && rd == rs1 && is_creg(rd) && rs2 != 5'd0) begin
              is_c = 1'b1; c_parcel = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
            end
          end
          F3_AND: begin
            if (rd == rs1 && is_creg(rd) && imm_6b) begin
              is_c = 1'b1; c_parcel = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            end
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && in_instr[31:12] != 20'd0 &&
            ((&in_instr[31:17]) | ~(|in_instr[31:17]))) begin
          is_c = 1'b1; c_parcel = {3'b011, in_instr[17], rd, in_instr[16:12], 2'b01};
        end
      end
      OPC_OP: begin
        if (f7 == F7_ZERO && f3 == F3_ADD) begin
          if (rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
            is_c = 1'b1; c_parcel = {4'b1000, rd, rs2, 2'b10};
          end else if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
            is_c = 1'b1; c_parcel = {4'b1001, rd, rs2, 2'b10};
          end
        end else if (((f7 == F7_ALT && f3 == F3_ADD) ||
                      (f7 == F7_ZERO && (f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND))) &&
                     rd == rs1 && is_creg(rd) && is_creg(rs2)) begin
          is_c = 1'b1; c_parcel = {6'b100011, rd[2:0], ca_op, rs2[2:0], 2'b01};
        end
      end
      OPC_LOAD: begin
        if (f3 == F3_W && imm_i[1:0] == 2'd0) begin
          if (is_creg(rs1) && is_creg(rd) && imm_i[11:7] == 5'd0) begin
            is_c = 1'b1;
            c_parcel = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
          end else if (rd != 5'd0 && rs1 == 5'd2 && imm_i[11:8] == 4'd0) begin
            is_c = 1'b1; c_parcel = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
          end
        end
      end
      OPC_STORE: begin
        if (f3 == F3_W && imm_s[1:0] == 2'd0) begin
          if (is_creg(rs1) && is_creg(rs2) && imm_s[11:7] == 5'd0) begin
            is_c = 1'b1;
            c_parcel = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
          end else if (rs1 == 5'd2 && imm_s[11:8] == 4'd0) begin
            is_c = 1'b1; c_parcel = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
          end
        end
      end
      OPC_JALR: begin
        if (f3 == F3_ADD && imm_i == 12'd0 && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
          is_c = 1'b1; c_parcel = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end
      end
      OPC_SYSTEM: begin
        if (in_instr == INSTR_EBREAK) begin
          is_c = 1'b1; c_parcel = 16'h9002;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ifu_compress_pack.sv
// Streaming RVC compressor and 16/32-bit parcel packer into little-endian 32-bit words.
// Optional RV_CPACK_STATS_EN adds saturating compressed/uncompressed beat counters.
module ifu_compress_pack
  import ifu_cpack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef RV_CPACK_STATS_EN
  ,
  output logic [31:0] cnt_c,
  output logic [31:0] cnt_w
`endif
);

  logic        is_c;
  logic [15:0] c_parcel;
  logic [1:0]  state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_free;
  logic        accept;

  ifu_compress_enc u_enc (
    .in_instr (in_instr),
    .is_c     (is_c),
    .c_parcel (c_parcel)
  );

  assign out_free  = ~out_valid_q | out_ready;
  assign in_ready  = (state_q != DRAIN) & out_free;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    if (state_q == DRAIN) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = {C_NOP, pend_q};
        state_d     = EMPTY;
      end
    end else if (accept) begin
      if (state_q == HALF) begin
        out_valid_d = 1'b1;
        if (is_c) begin
          out_data_d = {c_parcel, pend_q};
          state_d    = EMPTY;
        end else begin
          // Low half completes the word; high half becomes the new pending parcel.
          out_data_d = {in_instr[15:0], pend_q};
          pend_d     = in_instr[31:16];
        end
      end else if (is_c) begin
        pend_d  = c_parcel;
        state_d = HALF;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = in_instr;
      end
      if (in_last && state_d == HALF) state_d = DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= EMPTY;
      pend_q      <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef RV_CPACK_STATS_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_c <= 32'h0000_0000;
      cnt_w <= 32'h0000_0000;
    end else if (accept) begin
      if (is_c && cnt_c != 32'hFFFF_FFFF) cnt_c <= cnt_c + 32'd1;
      if (!is_c && cnt_w != 32'hFFFF_FFFF) cnt_w <= cnt_w + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_compress_pack.sv
// Scoreboard bench for ifu_compress_pack: directed beats push expected words, a monitor checks them.
module tb_ifu_compress_pack;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
`ifdef RV_CPACK_STATS_EN
  logic [31:0] cnt_c;
  logic [31:0] cnt_w;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_compress_pack dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RV_CPACK_STATS_EN
    ,
    .cnt_c     (cnt_c),
    .cnt_w     (cnt_w)
`endif
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stalled words stay put.
  initial begin : monitor
    logic [31:0] held;
    logic        hold_chk;
    held     = 32'h0;
    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check("hold_valid", {31'b0, out_valid}, 32'd1);
          check("hold_data", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %08h expected no word", out_data);
          end else begin
            check("word", out_data, exp_q.pop_front());
          end
        end
        hold_chk = out_valid && !out_ready;
        held     = out_data;
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef RV_CPACK_STATS_EN
    check("rst_cnt_c", cnt_c, 32'd0);
    check("rst_cnt_w", cnt_w, 32'd0);
`endif
    @(posedge clk);
    #1;

    // addi x1,x1,1 + add x10,x10,x11
    exp_q.push_back(32'h952E_0085);
    send(32'h0010_8093, 1'b0);
    send(32'h00B5_0533, 1'b0);
    wait_drain("drain_two_c");
`ifdef RV_CPACK_STATS_EN
    check("cnt_c_two", cnt_c, 32'd2);
`endif

    // Uncompressible beats from EMPTY pass straight through.
    exp_q.push_back(32'h0000_0463);
    exp_q.push_back(32'h0000_8093);
    send(32'h0000_0463, 1'b0);
    send(32'h0000_8093, 1'b0);
    wait_drain("drain_pass");

    // Half carry-over across a 32-bit instruction.
    exp_q.push_back(32'h0463_0085);
    exp_q.push_back(32'h952E_0000);
    send(32'h0010_8093, 1'b0);
    send(32'h0000_0463, 1'b0);
    send(32'h00B5_0533, 1'b1);
    wait_drain("drain_carry");

    // Flush pad after a lone compressed last beat.
    exp_q.push_back(32'h0001_0085);
    send(32'h0010_8093, 1'b1);
    @(negedge clk);
    check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("flush_in_ready_high", {31'b0, in_ready}, 32'd1);
    wait_drain("drain_flush");

    // c.jr + c.ebreak with 5 cycles of backpressure.
    exp_q.push_back(32'h9002_8082);
    out_ready = 1'b0;
    send(32'h0000_8067, 1'b0);
    send(32'h0010_0073, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_bp");

    // Assorted forms: c.li/c.lw, c.addi4spn/c.swsp, c.lui/c.sub, c.slli/c.addi16sp.
    exp_q.push_back(32'h4144_52FD);
    exp_q.push_back(32'hC406_0800);
    exp_q.push_back(32'h8C05_6185);
    exp_q.push_back(32'h7139_028E);
    exp_q.push_back(32'h0000_00EF);
    exp_q.push_back(32'h1234_5678);
    send(32'hFFF0_0293, 1'b0);
    send(32'h0045_2483, 1'b0);
    send(32'h0101_0413, 1'b0);
    send(32'h0011_2423, 1'b0);
    send(32'h0000_11B7, 1'b0);
    send(32'h4094_0433, 1'b0);
    send(32'h0032_9293, 1'b0);
    send(32'hFC01_0113, 1'b0);
    send(32'h0000_00EF, 1'b0);
    send(32'h1234_5678, 1'b0);
    wait_drain("drain_forms");
`ifdef RV_CPACK_STATS_EN
    check("cnt_c_total", cnt_c, 32'd15);
    check("cnt_w_total", cnt_w, 32'd5);
`endif

    // Park in DRAIN with a stalled word, then reset: both must vanish.
    out_ready = 1'b0;
    send(32'h0010_8093, 1'b0);
    send(32'h0000_0463, 1'b1);
    @(negedge clk);
    check("drain_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_l = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst_l     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0085_952E);
    send(32'h00B5_0533, 1'b0);
    send(32'h0010_8093, 1'b0);
    wait_drain("drain_post_rst");
`ifdef RV_CPACK_STATS_EN
    check("cnt_c_post_rst", cnt_c, 32'd2);
    check("cnt_w_post_rst", cnt_w, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
